// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Provides default widths, the hardwired-zero index and a read-port index type.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;
  localparam int MAX_RD     = 4;

  typedef logic [$clog2(MAX_RD)-1:0] rd_idx_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: storage mux, pend lookup, optional bypass.
// Ports: addr in; regs/pend storage in; wr_* for forwarding; data/busy out.
// With REGFILE_BYPASS_EN defined, a same-cycle write to addr is forwarded.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0]                    addr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]     regs,
  input  logic [2**ADDR_W-1:0]                 pend,
  input  logic                                 wr_en,
  input  logic [ADDR_W-1:0]                    wr_addr,
  input  logic [DATA_W-1:0]                    wr_data,
  output logic [DATA_W-1:0]                    data,
  output logic                                 busy
);

  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

  logic is_zero;
  assign is_zero = (addr == ZA);

`ifdef REGFILE_BYPASS_EN
  logic fwd;
  assign fwd = wr_en && (wr_addr != ZA) && (wr_addr == addr);
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  always_comb begin
    data = regs[addr];
    busy = pend[addr];
    if (is_zero) begin
      data = '0;
      busy = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    // Forwarded value is the one being written, so it cannot be pending
    // yet even if a reserve lands on the same edge.
    if (fwd) begin
      data = wr_data;
      busy = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register pending (scoreboard) bits.
// Ports: clk, rst; rd_addr/rd_data/rd_pend (NUM_RD packed ports);
// wr_en/wr_addr/wr_data write; rsv_en/rsv_addr reserve; pend_cnt count.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             pend;
  logic [DEPTH-1:0]             pend_nxt;

  logic wr_hit;
  logic rsv_hit;
  logic inc;
  logic dec;

  assign wr_hit  = wr_en && (wr_addr != ZA);
  assign rsv_hit = rsv_en && (rsv_addr != ZA);

  // Reserve is applied after the write clear so a new producer wins.
  always_comb begin
    pend_nxt = pend;
    if (wr_hit)
      pend_nxt[wr_addr] = 1'b0;
    if (rsv_hit)
      pend_nxt[rsv_addr] = 1'b1;
  end

  assign inc = rsv_hit && !pend[rsv_addr];
  assign dec = wr_hit && pend[wr_addr]
            && !(rsv_hit && (rsv_addr == wr_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs     <= '0;
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_hit)
        regs[wr_addr] <= wr_data;
      pend     <= pend_nxt;
      pend_cnt <= pend_cnt
                + (ADDR_W+1)'(inc)
                - (ADDR_W+1)'(dec);
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_read_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_port (
      .addr    (rd_addr[i*ADDR_W +: ADDR_W]),
      .regs    (regs),
      .pend    (pend),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rd_data[i*DATA_W +: DATA_W]),
      .busy    (rd_pend[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp with a reference model and
// a queue of expected read data popped when the ports are sampled.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_pend;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            rsv_en = 1'b0;
  logic [AW-1:0]   rsv_addr = '0;
  logic [AW:0]     pend_cnt;

  regfile_mp #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .NUM_RD(NR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_pend  (rd_pend),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .pend_cnt (pend_cnt)
  );

  always #5 clk = ~clk;

  int pass_n  = 0;
  int total_n = 0;

  logic [DW-1:0] m_reg [32];
  logic [31:0]   m_pend;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_v;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pend = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr[0*AW +: AW] = AW'(a0);
    rd_addr[1*AW +: AW] = AW'(a1);
  endtask

  // Clock one edge with the given strobes and update the model.
  task automatic commit(input logic we, input int wa, input logic [DW-1:0] wd,
                        input logic re, input int ra);
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    rsv_en = re; rsv_addr = AW'(ra);
    cyc();
    if (we && wa != 0) begin
      m_reg[wa]  = wd;
      m_pend[wa] = 1'b0;
    end
    if (re && ra != 0) m_pend[ra] = 1'b1;
    wr_en = 1'b0;
    rsv_en = 1'b0;
  endtask

  task automatic push_reads();
    exp_q.push_back(m_reg[rd_addr[0*AW +: AW]]);
    exp_q.push_back(m_reg[rd_addr[1*AW +: AW]]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    cyc();
    cyc();
    rst = 1'b0;
    set_rd(1, 2);
    #1;
    push_reads();
    for (int i = 0; i < NR; i++) begin
      exp_v = exp_q.pop_front();
      total_n++;
      if (rd_data[i*DW +: DW] !== exp_v)
        $display("FAIL reset_data p%0d: got %h want %h", i, rd_data[i*DW +: DW], exp_v);
      else pass_n++;
    end
    total_n++;
    if (rd_pend !== 2'b00) $display("FAIL reset_pend: got %b want 00", rd_pend);
    else pass_n++;
    total_n++;
    if (pend_cnt !== 6'd0) $display("FAIL reset_cnt: got %0d want 0", pend_cnt);
    else pass_n++;
  endtask

  task automatic test_write_read();
    commit(1'b1, 2, 32'd25, 1'b0, 0);
    set_rd(2, 0);
    #1;
    push_reads();
    exp_v = exp_q.pop_front();
    total_n++;
    if (rd_data[0 +: DW] !== exp_v || exp_v !== 32'd25)
      $display("FAIL wr_reg2: got %0d want 25", rd_data[0 +: DW]);
    else pass_n++;
    void'(exp_q.pop_front());
    commit(1'b1, 5, 32'd3, 1'b0, 0);
    set_rd(5, 5);
    #1;
    push_reads();
    for (int i = 0; i < NR; i++) begin
      exp_v = exp_q.pop_front();
      total_n++;
      if (rd_data[i*DW +: DW] !== exp_v)
        $display("FAIL wr_reg5 p%0d: got %h want %h", i, rd_data[i*DW +: DW], exp_v);
      else pass_n++;
    end
  endtask

  task automatic test_zero_reg();
    commit(1'b1, 0, 32'hDEADBEEF, 1'b1, 0);
    set_rd(0, 0);
    #1;
    push_reads();
    for (int i = 0; i < NR; i++) begin
      exp_v = exp_q.pop_front();
      total_n++;
      if (rd_data[i*DW +: DW] !== exp_v)
        $display("FAIL zero_data p%0d: got %h want %h", i, rd_data[i*DW +: DW], exp_v);
      else pass_n++;
    end
    total_n++;
    if (rd_pend !== 2'b00) $display("FAIL zero_pend: got %b want 00", rd_pend);
    else pass_n++;
    total_n++;
    if (pend_cnt !== 6'd0) $display("FAIL zero_cnt: got %0d want 0", pend_cnt);
    else pass_n++;
  endtask

  task automatic test_scoreboard();
    commit(1'b0, 0, '0, 1'b1, 7);
    set_rd(7, 2);
    #1;
    total_n++;
    if (rd_pend !== {1'b0, m_pend[7]} || !m_pend[7])
      $display("FAIL rsv7_pend: got %b want 01", rd_pend);
    else pass_n++;
    total_n++;
    if (pend_cnt !== 6'($countones(m_pend)))
      $display("FAIL rsv7_cnt: got %0d want %0d", pend_cnt, $countones(m_pend));
    else pass_n++;
    commit(1'b0, 0, '0, 1'b1, 7);
    total_n++;
    if (pend_cnt !== 6'd1) $display("FAIL rsv7_again_cnt: got %0d want 1", pend_cnt);
    else pass_n++;
    commit(1'b1, 7, 32'h55, 1'b0, 0);
    #1;
    push_reads();
    exp_v = exp_q.pop_front();
    total_n++;
    if (rd_data[0 +: DW] !== exp_v)
      $display("FAIL wr7_data: got %h want %h", rd_data[0 +: DW], exp_v);
    else pass_n++;
    void'(exp_q.pop_front());
    total_n++;
    if (rd_pend[0] !== 1'b0 || pend_cnt !== 6'd0)
      $display("FAIL wr7_clear: got pend %b cnt %0d want 0 0", rd_pend[0], pend_cnt);
    else pass_n++;
    commit(1'b1, 9, 32'hA5A5_0009, 1'b1, 9);
    set_rd(9, 9);
    #1;
    push_reads();
    for (int i = 0; i < NR; i++) begin
      exp_v = exp_q.pop_front();
      total_n++;
      if (rd_data[i*DW +: DW] !== exp_v)
        $display("FAIL wr_rsv9 p%0d: got %h want %h", i, rd_data[i*DW +: DW], exp_v);
      else pass_n++;
    end
    total_n++;
    if (rd_pend !== 2'b11 || pend_cnt !== 6'd1)
      $display("FAIL wr_rsv9_pend: got %b cnt %0d want 11 1", rd_pend, pend_cnt);
    else pass_n++;
  endtask

  task automatic test_bypass();
    set_rd(3, 3);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h1234);
`else
    push_reads();
`endif
    for (int i = 0; i < NR; i++) begin
      exp_v = exp_q.pop_front();
      total_n++;
      if (rd_data[i*DW +: DW] !== exp_v)
        $display("FAIL byp_pre p%0d: got %h want %h", i, rd_data[i*DW +: DW], exp_v);
      else pass_n++;
    end
    total_n++;
    if (rd_pend !== 2'b00) $display("FAIL byp_pre_pend: got %b want 00", rd_pend);
    else pass_n++;
    commit(1'b1, 3, 32'h1234, 1'b1, 3);
    #1;
    push_reads();
    for (int i = 0; i < NR; i++) begin
      exp_v = exp_q.pop_front();
      total_n++;
      if (rd_data[i*DW +: DW] !== exp_v)
        $display("FAIL byp_post p%0d: got %h want %h", i, rd_data[i*DW +: DW], exp_v);
      else pass_n++;
    end
    total_n++;
    if (rd_pend !== 2'b11 || pend_cnt !== 6'd2)
      $display("FAIL byp_post_pend: got %b cnt %0d want 11 2", rd_pend, pend_cnt);
    else pass_n++;
  endtask

  task automatic test_async_reset();
    for (int r = 1; r <= 4; r++)
      commit(1'b1, r, 32'h100 + DW'(r), 1'b0, 0);
    commit(1'b0, 0, '0, 1'b1, 10);
    commit(1'b0, 0, '0, 1'b1, 11);
    set_rd(1, 4);
    #1;
    push_reads();
    for (int i = 0; i < NR; i++) begin
      exp_v = exp_q.pop_front();
      total_n++;
      if (rd_data[i*DW +: DW] !== exp_v)
        $display("FAIL pre_rst p%0d: got %h want %h", i, rd_data[i*DW +: DW], exp_v);
      else pass_n++;
    end
    total_n++;
    if (pend_cnt !== 6'($countones(m_pend)))
      $display("FAIL pre_rst_cnt: got %0d want %0d", pend_cnt, $countones(m_pend));
    else pass_n++;
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    push_reads();
    for (int i = 0; i < NR; i++) begin
      exp_v = exp_q.pop_front();
      total_n++;
      if (rd_data[i*DW +: DW] !== exp_v)
        $display("FAIL async_rst p%0d: got %h want %h", i, rd_data[i*DW +: DW], exp_v);
      else pass_n++;
    end
    total_n++;
    if (pend_cnt !== 6'd0) $display("FAIL async_rst_cnt: got %0d want 0", pend_cnt);
    else pass_n++;
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd1;
    cyc();
    wr_en = 1'b0;
    rsv_en = 1'b0;
    rst = 1'b0;
    #1;
    push_reads();
    for (int i = 0; i < NR; i++) begin
      exp_v = exp_q.pop_front();
      total_n++;
      if (rd_data[i*DW +: DW] !== exp_v)
        $display("FAIL rst_ignore p%0d: got %h want %h", i, rd_data[i*DW +: DW], exp_v);
      else pass_n++;
    end
    total_n++;
    if (rd_pend !== 2'b00 || pend_cnt !== 6'd0)
      $display("FAIL rst_ignore_pend: got %b cnt %0d want 00 0", rd_pend, pend_cnt);
    else pass_n++;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++)
      commit(1'b1, 20 + k, $urandom, 1'b1, 26 - k);
    for (int k = 0; k < 6; k += 2) begin
      set_rd(20 + k, 21 + k);
      #1;
      push_reads();
      for (int i = 0; i < NR; i++) begin
        exp_v = exp_q.pop_front();
        total_n++;
        if (rd_data[i*DW +: DW] !== exp_v)
          $display("FAIL b2b r%0d p%0d: got %h want %h", 20 + k, i, rd_data[i*DW +: DW], exp_v);
        else pass_n++;
      end
      total_n++;
      if (rd_pend !== {m_pend[21 + k], m_pend[20 + k]})
        $display("FAIL b2b_pend r%0d: got %b want %b", 20 + k, rd_pend,
                 {m_pend[21 + k], m_pend[20 + k]});
      else pass_n++;
    end
    total_n++;
    if (pend_cnt !== 6'($countones(m_pend)))
      $display("FAIL b2b_cnt: got %0d want %0d", pend_cnt, $countones(m_pend));
    else pass_n++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_scoreboard();
    test_bypass();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised, clocked successor to the MIPS datapath register file.
- Provides NUM_RD combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- A per-register pending (scoreboard) bit tracks in-flight producers, so the decode stage can detect RAW hazards without external tracking logic.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port i = bits [i*DATA_W +: DATA_W]
- rd_pend  out  NUM_RD  port i's register has an outstanding reservation
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve strobe; marks a register pending (issued producer)
- rsv_addr  in  ADDR_W  register to reserve
- pend_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (async, rst=1):
  - all registers = 0
  - all pending bits = 0
  - pend_cnt = 0
  - every rd_data = 0, every rd_pend = 0
  - wr_en/rsv_en ignored while rst is high
- Read:
  - combinational, zero latency from rd_addr.
  - rd_data[i] = reg[rd_addr[i]]; address 0 always returns 0.
- Write:
  - on posedge clk with wr_en=1 and wr_addr!=0: reg[wr_addr] <= wr_data; pend[wr_addr] <= 0.
  - wr_addr==0: no effect.
- Reserve:
  - on posedge clk with rsv_en=1 and rsv_addr!=0: pend[rsv_addr] <= 1.
  - rsv_addr==0: no effect; reg 0 is never pending.
- Simultaneous write and reserve:
  - same address: data is written, and pend ends at 1 (reserve wins; new producer supersedes).
  - different addresses: both take effect independently.
- rd_pend[i] = pend[rd_addr[i]] (combinational).
- pend_cnt is a registered counter updated each edge by net change:
  - +1 if a reserve sets a previously clear bit
  - -1 if a write clears a previously set bit (and not re-reserved the same cycle)
  - range 0..2**ADDR_W-1; no wrap is possible by construction.
- Write to a non-pending register: legal; data updated, pend stays 0.
- Reserve on an already-pending register: pend stays 1, count unchanged.
- Multiple read ports may address the same register; all return identical data.
- Reset mid-operation: state is cleared immediately on rst assertion, independent of clk; the first update occurs on the first posedge after deassertion.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - Same-cycle write-through forwarding. If wr_en=1, wr_addr!=0 and rd_addr[i]==wr_addr, then rd_data[i]=wr_data and rd_pend[i]=0 combinationally, before the edge.
  - If rsv_en also targets that address in the same cycle, rd_pend[i] still shows 0 until the edge.
- Undefined:
  - Reads return stored contents; the new value is visible from the cycle after the write edge.
  - rd_pend reflects stored pend bits only.

Decomposition:
- Shared package regfile_pkg:
  - default DATA_W/ADDR_W constants
  - localparam ZERO_REG = 0
  - a read-port index typedef
- One natural sub-module, regfile_read_port: a single read mux plus the bypass compare, instantiated NUM_RD times in a generate loop.
- Storage, pend bits and pend_cnt stay in the top level.

Test Plan:
1. Reset then read: rst pulse; rd_addr = {1,2} → rd_data = {0,0}, rd_pend = 0, pend_cnt = 0.
2. Basic write/read: write reg2 = 25 (matching legacy stimulus); next cycle rd_addr[0]=2 → 25. Write reg5 = 3, read on both ports → 3, 3.
3. Zero register: write reg0 = 0xDEADBEEF, reserve reg0 → reads of 0 return 0; rd_pend = 0; pend_cnt stays 0.
4. Scoreboard:
   - reserve 7 → rd_pend for 7 = 1, pend_cnt = 1
   - reserve 7 again → pend_cnt = 1
   - write 7 = 0x55 → pend = 0, pend_cnt = 0
   - same-cycle reserve+write 9 → data 9 = written value, pend = 1, pend_cnt = 1
5. Bypass: write reg3 = 0x1234 while reading 3 in the same cycle.
   - With REGFILE_BYPASS_EN: rd_data = 0x1234 before the edge.
   - Without: old value (0) before the edge, 0x1234 after.
6. Async reset mid-run: after writes to 1..4 and reserves on 10, 11, assert rst between edges → all rd_data = 0 and pend_cnt = 0 immediately, without a clock edge.
